// File: rtl/dlfloat_mac_host.sv
// Host-side driver for the two-byte-framed DLFloat MAC pin protocol: serializes operand
// pairs onto the DUT bus and reassembles the DUT's result byte stream into 16-bit words.
module dlfloat_mac_host #(
    parameter int unsigned RES_LAT = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_resync,
    input  logic             i_op_valid,
    input  logic [15:0]      i_op_a,
    input  logic [15:0]      i_op_b,
    output logic             o_op_ready,
    output logic             o_res_valid,
    output logic [15:0]      o_res_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_issued_cnt,
    output logic             o_dut_rst_n,
    output logic [7:0]       o_dut_ui,
    output logic [7:0]       o_dut_uio,
    input  logic [7:0]       i_dut_uo
);
    localparam int unsigned PEND_W = $clog2(RES_LAT + 3);

    typedef enum logic [1:0] {StIdle, StAOut, StBOut} state_t;

    state_t             r_state;
    logic               r_dut_rst_n;
    logic               r_phase;
    logic [15:0]        r_bus;
    logic [15:0]        r_b_hold;
    logic [RES_LAT+1:1] r_trk;
    logic [7:0]         r_lo;
    logic               r_res_valid;
    logic [15:0]        r_res_data;
    logic [PEND_W-1:0]  r_pend_cnt;
    logic [CNT_W-1:0]   r_issued_cnt;
    logic               w_accept;
    logic               w_b_cycle;

    assign o_op_ready   = r_dut_rst_n & r_phase & ~i_resync;
    assign w_accept     = i_op_valid & o_op_ready;
    assign w_b_cycle    = (r_state == StBOut);
    assign o_dut_rst_n  = r_dut_rst_n;
    assign o_dut_ui     = r_bus[7:0];
    assign o_dut_uio    = r_bus[15:8];
    assign o_res_valid  = r_res_valid;
    assign o_res_data   = r_res_data;
    assign o_issued_cnt = r_issued_cnt;
    assign o_busy       = (r_state != StIdle) | (r_pend_cnt != '0);

    // Phase stays 0 through the DUT reset cycle so both sides start counting together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dut_rst_n <= 1'b0;
            r_phase     <= 1'b0;
        end else begin
            r_dut_rst_n <= ~i_resync;
            r_phase     <= (r_dut_rst_n & ~i_resync) ? ~r_phase : 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_bus    <= '0;
            r_b_hold <= '0;
        end else if (i_resync) begin
            r_state <= StIdle;
            r_bus   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_bus    <= i_op_a;
                        r_b_hold <= i_op_b;
                        r_state  <= StAOut;
                    end
                end
                StAOut: begin
                    r_bus   <= r_b_hold;
                    r_state <= StBOut;
                end
                StBOut: begin
                    if (w_accept) begin
                        r_bus    <= i_op_a;
                        r_b_hold <= i_op_b;
                        r_state  <= StAOut;
                    end else begin
                        r_bus   <= '0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Tap 0 is the B cycle itself; r_trk[k] marks the cycle k after it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_trk       <= '0;
            r_lo        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (i_resync) begin
            r_trk       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_trk       <= {r_trk[RES_LAT:1], w_b_cycle};
            r_res_valid <= r_trk[RES_LAT+1];
            if (r_trk[RES_LAT]) begin
                r_lo <= i_dut_uo;
            end
            if (r_trk[RES_LAT+1]) begin
                r_res_data <= {i_dut_uo, r_lo};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_cnt   <= '0;
            r_issued_cnt <= '0;
        end else if (i_resync) begin
            r_pend_cnt   <= '0;
            r_issued_cnt <= '0;
        end else begin
            case ({w_b_cycle, r_res_valid})
                2'b10:   r_pend_cnt <= r_pend_cnt + PEND_W'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - PEND_W'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
            if (w_b_cycle) begin
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_host.sv
// Self-checking bench for dlfloat_mac_host: directed vector table, corner sequences and
// randomized traffic checked cycle by cycle against a schedule-based reference model.
module tb_dlfloat_mac_host;
    localparam int L    = 5;
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        resync = 1'b0;
    logic        op_valid = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [7:0]  dut_uo = '0;

    logic        op_ready, res_valid, busy, dut_rst_n;
    logic [15:0] res_data;
    logic [7:0]  issued_cnt, dut_ui, dut_uio;
    logic        w_op_ready, w_res_valid, w_busy, w_dut_rst_n;
    logic [15:0] w_res_data;
    logic [1:0]  w_issued_cnt;
    logic [7:0]  w_dut_ui, w_dut_uio;

    always #5 clk = ~clk;

    dlfloat_mac_host #(.RES_LAT(L), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_resync(resync), .i_op_valid(op_valid),
        .i_op_a(op_a), .i_op_b(op_b), .o_op_ready(op_ready), .o_res_valid(res_valid),
        .o_res_data(res_data), .o_busy(busy), .o_issued_cnt(issued_cnt),
        .o_dut_rst_n(dut_rst_n), .o_dut_ui(dut_ui), .o_dut_uio(dut_uio), .i_dut_uo(dut_uo)
    );

    dlfloat_mac_host #(.RES_LAT(L), .CNT_W(2)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_resync(resync), .i_op_valid(op_valid),
        .i_op_a(op_a), .i_op_b(op_b), .o_op_ready(w_op_ready), .o_res_valid(w_res_valid),
        .o_res_data(w_res_data), .o_busy(w_busy), .o_issued_cnt(w_issued_cnt),
        .o_dut_rst_n(w_dut_rst_n), .o_dut_ui(w_dut_ui), .o_dut_uio(w_dut_uio),
        .i_dut_uo(dut_uo)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: what the bus, strobes and counters must show in each cycle.
    logic [15:0] m_bus [MAXC];
    bit          m_act [MAXC];
    bit          m_b   [MAXC];
    bit          m_val [MAXC];
    logic [7:0]  uo_hist [MAXC];
    int          base, rs_last, m_iss, m_pend;
    logic [15:0] m_res;

    bit          s_acc, s_valid, s_rstn, s_ready, s_busy;
    logic [15:0] s_data, s_bus;
    logic [7:0]  s_iss;
    logic [1:0]  s_iss_w;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] res;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_rstn(input int c);
        return c != rs_last + 1;
    endfunction

    function automatic bit m_phase(input int c);
        if (c == rs_last + 1) return 1'b0;
        return ((c - base) % 2) != 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < MAXC; k++) begin
            m_bus[k] = '0; m_act[k] = 0; m_b[k] = 0; m_val[k] = 0; uo_hist[k] = '0;
        end
        cyc = 0; base = 0; rs_last = -100; m_iss = 0; m_pend = 0; m_res = '0;
    endtask

    task automatic do_reset();
        op_valid = 0; resync = 0; dut_uo = '0;
        rst = 1'b1;
        #1;
        chk("rst_dut_rst_n", dut_rst_n, 0);
        chk("rst_bus", {dut_uio, dut_ui}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_issued_w", w_issued_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic run_cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                             input bit rs, input logic [7:0] uo);
        bit e_rstn, e_ready;
        if (cyc + L + 6 >= MAXC) begin
            $display("FAIL model_overflow cyc=%0d got=%0d want<%0d", cyc, cyc, MAXC);
            $fatal(1);
        end
        op_valid = v; op_a = a; op_b = b; resync = rs; dut_uo = uo;
        uo_hist[cyc] = uo;
        @(negedge clk);
        e_rstn  = m_rstn(cyc);
        e_ready = e_rstn & m_phase(cyc) & ~rs;
        if (m_val[cyc]) m_res = {uo_hist[cyc-1], uo_hist[cyc-2]};
        chk("dut_rst_n", dut_rst_n, e_rstn);
        chk("op_ready", op_ready, e_ready);
        chk("bus", {dut_uio, dut_ui}, m_bus[cyc]);
        chk("res_valid", res_valid, m_val[cyc]);
        chk("res_data", res_data, m_res);
        chk("busy", busy, m_act[cyc] || m_pend != 0);
        chk("issued_cnt", issued_cnt, m_iss % 256);
        chk("issued_cnt_w", w_issued_cnt, m_iss % 4);
        s_acc = v & e_ready; s_valid = res_valid; s_data = res_data; s_rstn = dut_rst_n;
        s_ready = op_ready; s_busy = busy; s_bus = {dut_uio, dut_ui};
        s_iss = issued_cnt; s_iss_w = w_issued_cnt;
        if (s_acc) begin
            m_bus[cyc+1] = a; m_bus[cyc+2] = b;
            m_act[cyc+1] = 1; m_act[cyc+2] = 1;
            m_b[cyc+2] = 1;
            m_val[cyc+4+L] = 1;
        end
        if (rs) begin
            for (int k = cyc + 1; k < MAXC; k++) begin
                m_bus[k] = '0; m_act[k] = 0; m_b[k] = 0; m_val[k] = 0;
            end
            m_iss = 0; m_pend = 0; rs_last = cyc; base = cyc + 2;
        end else begin
            m_iss  = m_iss + int'(m_b[cyc]);
            m_pend = m_pend + int'(m_b[cyc]) - int'(m_val[cyc]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycle();
        run_cycle(0, '0, '0, 0, 8'($urandom));
    endtask

    task automatic wait_slot(input bit want_phase);
        int n = 0;
        while (!(m_rstn(cyc) && m_phase(cyc) == want_phase && !m_act[cyc] && m_pend == 0)
               && n < 40) begin
            idle_cycle();
            n++;
        end
        if (n >= 40) chk("wait_slot_timeout", 0, 1);
    endtask

    initial begin
        int nacc, nlow, nstr;
        int sq[$];
        logic [1:0] wq[$];
        logic [1:0] prev_w;
        int exp_w[5] = '{1, 2, 3, 0, 1};
        logic [7:0] uo;

        tbl[0] = '{16'h3E00, 16'h3E00, 8'h00, 8'h3E, 16'h3E00};
        tbl[1] = '{16'h4000, 16'hBC00, 8'h00, 8'hC2, 16'hC200};
        tbl[2] = '{16'h0000, 16'h7FFF, 8'hFF, 8'hFF, 16'hFFFF};
        tbl[3] = '{16'h8001, 16'h0001, 8'h34, 8'h12, 16'h1234};

        do_reset();
        idle_cycle();
        chk("first_rstn_high", s_rstn, 1);
        chk("first_ready_low", s_ready, 0);
        idle_cycle();
        chk("ready_after_release", s_ready, 1);

        // Directed single pairs from the vector table.
        for (int i = 0; i < 4; i++) begin
            wait_slot(1);
            run_cycle(1, tbl[i].a, tbl[i].b, 0, 8'($urandom));
            for (int k = 1; k <= L + 5; k++) begin
                uo = (k == 2 + L) ? tbl[i].lo : (k == 3 + L) ? tbl[i].hi : 8'($urandom);
                run_cycle(0, '0, '0, 0, uo);
                if (k == 1) chk("tbl_bus_a", s_bus, tbl[i].a);
                if (k == 2) chk("tbl_bus_b", s_bus, tbl[i].b);
                if (k == 3) chk("tbl_bus_idle", s_bus, 0);
                if (k == 4 + L) begin
                    chk("tbl_res_valid", s_valid, 1);
                    chk("tbl_res_data", s_data, tbl[i].res);
                end
            end
        end

        // Back-to-back four pairs with op_valid held high.
        wait_slot(1);
        nacc = 0;
        for (int n = 0; n < 20 && nacc < 4; n++) begin
            run_cycle(1, 16'($urandom), 16'($urandom), 0, 8'($urandom));
            if (s_acc) nacc++;
        end
        chk("b2b_accepts", nacc, 4);
        sq.delete();
        for (int n = 0; n < 16; n++) begin
            idle_cycle();
            if (s_valid) sq.push_back(cyc - 1);
        end
        chk("b2b_strobes", sq.size(), 4);
        for (int i = 1; i < sq.size(); i++) chk("b2b_gap", sq[i] - sq[i-1], 2);
        chk("b2b_issued", s_iss, 8);
        chk("b2b_idle_busy", s_busy, 0);

        // op_valid raised in a phase-0 cycle waits for the next phase-1 cycle.
        wait_slot(0);
        run_cycle(1, 16'hA5A5, 16'h5A5A, 0, 8'($urandom));
        chk("ph0_no_accept", s_ready, 0);
        chk("ph0_bus_still", s_bus, 0);
        run_cycle(1, 16'hA5A5, 16'h5A5A, 0, 8'($urandom));
        chk("ph1_accept", s_ready, 1);
        run_cycle(0, '0, '0, 0, 8'($urandom));
        chk("ph1_bus_a", s_bus, 16'hA5A5);
        for (int n = 0; n < 12; n++) idle_cycle();

        // Resync with two results pending.
        wait_slot(1);
        nacc = 0;
        for (int n = 0; n < 10 && nacc < 2; n++) begin
            run_cycle(1, 16'($urandom), 16'($urandom), 0, 8'($urandom));
            if (s_acc) nacc++;
        end
        repeat (3) idle_cycle();
        chk("rs_pending_busy", s_busy, 1);
        run_cycle(0, '0, '0, 1, 8'($urandom));
        nlow = 0; nstr = 0;
        for (int n = 0; n < 15; n++) begin
            idle_cycle();
            if (!s_rstn) nlow++;
            if (s_valid) nstr++;
        end
        chk("rs_low_cycles", nlow, 1);
        chk("rs_no_strobes", nstr, 0);
        chk("rs_issued_zero", s_iss, 0);
        chk("rs_busy_zero", s_busy, 0);
        wait_slot(1);
        run_cycle(1, 16'h1357, 16'h2468, 0, 8'($urandom));
        for (int n = 0; n < 12; n++) idle_cycle();

        // Counter wrap on the CNT_W=2 instance.
        do_reset();
        wait_slot(1);
        wq.delete();
        prev_w = 2'd0;
        nacc = 0;
        for (int n = 0; n < 30; n++) begin
            run_cycle(nacc < 5, 16'($urandom), 16'($urandom), 0, 8'($urandom));
            if (s_acc) nacc++;
            if (s_iss_w != prev_w) wq.push_back(s_iss_w);
            prev_w = s_iss_w;
        end
        chk("wrap_len", wq.size(), 5);
        for (int i = 0; i < 5 && i < wq.size(); i++) chk("wrap_seq", wq[i], exp_w[i]);

        // Randomized traffic with occasional resync.
        for (int n = 0; n < 1200; n++) begin
            run_cycle($urandom_range(0, 9) < 6, 16'($urandom), 16'($urandom),
                      $urandom_range(0, 99) == 0, 8'($urandom));
        end

        // Asynchronous reset in the middle of a transfer.
        wait_slot(1);
        run_cycle(1, 16'hBEEF, 16'hCAFE, 0, 8'($urandom));
        run_cycle(0, '0, '0, 0, 8'($urandom));
        do_reset();
        for (int n = 0; n < 4; n++) idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
